// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: decodes A5-framed host commands from uart_rx bytes and issues single-byte
// RAM / VIC-II register writes over a req/ack bus, with length, range, checksum and timeout checks.
module uart_cmd_ctrl #(
    parameter int TIMEOUT_CLKS = 64125000 / 100,
    parameter int VIC_REG_SPAN = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        wr_req,
    output logic        wr_sel,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    input  logic        wr_ack,
    output logic        busy,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [2:0]  err_code
);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    typedef enum logic [2:0] {S_SYNC, S_CMD, S_AHI, S_ALO, S_LEN, S_DATA, S_CHK} state_t;
    state_t        state_q, state_d;
    logic          sel_q, sel_d;
    logic [15:0]   addr_q, addr_d;
    logic [8:0]    rem_q, rem_d;
    logic [7:0]    chk_q, chk_d;
    logic          got_chk_q, got_chk_d, chk_bad_q, chk_bad_d;
    logic          hold_v_q, hold_v_d, issue_q, issue_d;
    logic [7:0]    hold_q, hold_d;
    logic          wr_req_q, wr_req_d, wr_sel_q, wr_sel_d;
    logic [15:0]   wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          frame_ok_q, frame_ok_d, frame_err_q, frame_err_d, busy_q, busy_d;
    logic [2:0]    err_code_q, err_code_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          pay, abort, tmo_hit, hv, pend;
    logic [8:0]    len_n;
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        chk_d       = chk_q;
        got_chk_d   = got_chk_q;
        chk_bad_d   = chk_bad_q;
        hold_d      = hold_q;
        issue_d     = issue_q;
        wr_req_d    = wr_req_q;
        wr_sel_d    = wr_sel_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        pay         = 1'b0;
        abort       = 1'b0;
        tmo_hit     = state_q != S_SYNC && !got_chk_q && !rx_valid && tmo_q == TW'(TIMEOUT_CLKS - 1);
        tmo_d       = (rx_valid || state_q == S_SYNC) ? '0 : tmo_q + 1'b1;
        hv          = hold_v_q && !tmo_hit;
        hold_v_d    = hv;
        pend        = (wr_req_q && !wr_ack) || issue_q;
        len_n       = {rx_data == 8'h00, rx_data};
        case (state_q)
            S_SYNC: if (rx_valid && rx_data == 8'hA5) begin
                state_d   = S_CMD;
                got_chk_d = 1'b0;
            end
            S_CMD: if (rx_valid) begin
                chk_d = rx_data;
                sel_d = rx_data == 8'h02;
                if (rx_data == 8'h01 || rx_data == 8'h02) state_d = S_AHI;
                else begin
                    state_d     = S_SYNC;
                    frame_err_d = 1'b1;
                    err_code_d  = 3'd1;
                end
            end
            S_AHI: if (rx_valid) begin
                chk_d         = chk_q ^ rx_data;
                addr_d[15:8]  = rx_data;
                state_d       = S_ALO;
            end
            S_ALO: if (rx_valid) begin
                chk_d        = chk_q ^ rx_data;
                addr_d[7:0]  = rx_data;
                state_d      = S_LEN;
            end
            S_LEN: if (rx_valid) begin
                chk_d = chk_q ^ rx_data;
                rem_d = len_n;
                if (sel_q && {1'b0, addr_q} + {8'b0, len_n} > 17'(VIC_REG_SPAN)) begin
                    state_d     = S_SYNC;
                    frame_err_d = 1'b1;
                    err_code_d  = 3'd2;
                end else state_d = S_DATA;
            end
            S_DATA: if (rx_valid) begin
                if (pend && hold_v_q) begin
                    abort       = 1'b1;
                    state_d     = S_SYNC;
                    frame_err_d = 1'b1;
                    err_code_d  = 3'd4;
                end else begin
                    pay     = 1'b1;
                    chk_d   = chk_q ^ rx_data;
                    rem_d   = rem_q - 1'b1;
                    state_d = rem_q == 9'd1 ? S_CHK : S_DATA;
                end
            end
            S_CHK: if (!got_chk_q) begin
                if (rx_valid) begin
                    got_chk_d = 1'b1;
                    chk_bad_d = rx_data != chk_q;
                end
            end else if (!wr_req_q && !issue_q && !hold_v_q) begin
                state_d     = S_SYNC;
                frame_ok_d  = !chk_bad_q;
                frame_err_d = chk_bad_q;
                err_code_d  = chk_bad_q ? 3'd5 : err_code_q;
            end
            default: state_d = S_SYNC;
        endcase
        if (tmo_hit) begin
            state_d     = S_SYNC;
            frame_err_d = 1'b1;
            err_code_d  = 3'd3;
        end
        // An ack frees the bus at once; the next byte is staged and requested one cycle later.
        if (wr_req_q && wr_ack) begin
            wr_req_d = 1'b0;
            if (hv || pay) begin
                issue_d   = 1'b1;
                wr_data_d = hv ? hold_q : rx_data;
                wr_addr_d = addr_q;
                wr_sel_d  = sel_q;
                addr_d    = addr_q + 16'd1;
                hold_v_d  = hv && pay;
                hold_d    = rx_data;
            end
        end else begin
            if (issue_q) begin
                wr_req_d = 1'b1;
                issue_d  = 1'b0;
            end
            if (pay && (wr_req_q || issue_q)) begin
                hold_v_d = 1'b1;
                hold_d   = rx_data;
            end else if (pay) begin
                wr_req_d  = 1'b1;
                wr_data_d = rx_data;
                wr_addr_d = addr_q;
                wr_sel_d  = sel_q;
                addr_d    = addr_q + 16'd1;
            end
        end
        if (abort) hold_v_d = 1'b0;
        busy_d = state_d != S_SYNC;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_SYNC;
            sel_q       <= 1'b0;
            addr_q      <= '0;
            rem_q       <= '0;
            chk_q       <= '0;
            got_chk_q   <= 1'b0;
            chk_bad_q   <= 1'b0;
            hold_v_q    <= 1'b0;
            hold_q      <= '0;
            issue_q     <= 1'b0;
            wr_req_q    <= 1'b0;
            wr_sel_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= '0;
            busy_q      <= 1'b0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            chk_q       <= chk_d;
            got_chk_q   <= got_chk_d;
            chk_bad_q   <= chk_bad_d;
            hold_v_q    <= hold_v_d;
            hold_q      <= hold_d;
            issue_q     <= issue_d;
            wr_req_q    <= wr_req_d;
            wr_sel_q    <= wr_sel_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
            busy_q      <= busy_d;
            tmo_q       <= tmo_d;
        end
    end
    assign wr_req    = wr_req_q;
    assign wr_sel    = wr_sel_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: randomized frames checked against a frame-level reference model
// (expected write list and outcome derived directly from the frame rules).
module tb_uart_cmd_ctrl;
    localparam int TMO = 300;
    typedef logic [7:0] bq_t[$];
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        wr_req, wr_sel, wr_ack, busy, frame_ok, frame_err;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic [2:0]  err_code;
    int checks = 0, failures = 0;
    int ok_cnt = 0, err_cnt = 0, both_cnt = 0, busy_viol = 0, stab_viol = 0;
    logic [2:0]  last_code = '0;
    logic [24:0] wq[$];
    int  max_dly = 2;
    bit  ack_hold = 1'b0;
    always #5 clk = ~clk;
    uart_cmd_ctrl #(.TIMEOUT_CLKS(TMO), .VIC_REG_SPAN(64)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .wr_req(wr_req), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .busy(busy), .frame_ok(frame_ok), .frame_err(frame_err),
        .err_code(err_code)
    );
    // Bus slave: random ack latency, records each accepted write, checks request stability.
    initial begin
        int cnt, dly;
        logic [24:0] cur;
        cnt = 0;
        cur = '0;
        dly = $urandom_range(0, max_dly);
        wr_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (wr_ack || !wr_req) begin
                wr_ack = 1'b0;
                cnt = 0;
            end else begin
                if (cnt == 0) cur = {wr_sel, wr_addr, wr_data};
                else if (cur !== {wr_sel, wr_addr, wr_data}) stab_viol++;
                if (!ack_hold && cnt >= dly) begin
                    wr_ack = 1'b1;
                    wq.push_back(cur);
                    dly = $urandom_range(0, max_dly);
                end
                cnt++;
            end
        end
    end
    initial forever begin
        @(posedge clk); #1;
        if (frame_ok && frame_err) both_cnt++;
        if ((frame_ok || frame_err) && busy) busy_viol++;
        if (frame_ok) ok_cnt++;
        if (frame_err) begin
            err_cnt++;
            last_code = err_code;
        end
    end
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        tick(gap);
    endtask
    function automatic bq_t rand_pl(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction
    task automatic run_frame(input string name, input logic [7:0] cmd, input logic [15:0] addr,
                             input int len, input bq_t pl, input bit bad_chk, input int gmin, input int gmax);
        bq_t bytes;
        logic [24:0] exp_w[$];
        logic [24:0] got;
        logic [7:0] chk;
        int exp_code, ok0, err0, n;
        bit vic;
        vic = cmd == 8'h02;
        chk = cmd ^ addr[15:8] ^ addr[7:0] ^ 8'(len);
        foreach (pl[i]) chk ^= pl[i];
        if (bad_chk) chk ^= 8'(1 << $urandom_range(0, 7));
        bytes = '{8'hA5, cmd};
        if (cmd != 8'h01 && cmd != 8'h02) exp_code = 1;
        else begin
            bytes.push_back(addr[15:8]);
            bytes.push_back(addr[7:0]);
            bytes.push_back(8'(len));
            if (vic && int'(addr) + len > 64) exp_code = 2;
            else begin
                foreach (pl[i]) begin
                    bytes.push_back(pl[i]);
                    exp_w.push_back({vic, 16'(int'(addr) + i), pl[i]});
                end
                bytes.push_back(chk);
                exp_code = bad_chk ? 5 : 0;
            end
        end
        ok0 = ok_cnt;
        err0 = err_cnt;
        wq.delete();
        foreach (bytes[i]) send_byte(bytes[i], $urandom_range(gmin, gmax));
        n = 0;
        while (ok_cnt == ok0 && err_cnt == err0 && n < 3000) begin
            tick(1);
            n++;
        end
        tick(4);
        checks++;
        if (exp_code == 0 ? (ok_cnt - ok0 != 1 || err_cnt != err0)
                          : (err_cnt - err0 != 1 || ok_cnt != ok0 || last_code !== 3'(exp_code))) begin
            failures++;
            $display("FAIL %s outcome: got ok+%0d err+%0d code=%0d, want code %0d (0 = frame_ok)",
                     name, ok_cnt - ok0, err_cnt - err0, last_code, exp_code);
        end
        checks++;
        if (wq.size() != exp_w.size()) begin
            failures++;
            $display("FAIL %s write_count: got %0d want %0d", name, wq.size(), exp_w.size());
        end
        foreach (exp_w[i]) begin
            got = (i < wq.size()) ? wq[i] : 'x;
            checks++;
            if (got !== exp_w[i]) begin
                failures++;
                $display("FAIL %s write[%0d]: got sel/addr/data %h want %h", name, i, got, exp_w[i]);
            end
        end
        checks++;
        if (busy !== 1'b0 || wr_req !== 1'b0) begin
            failures++;
            $display("FAIL %s idle_after: busy=%b wr_req=%b want 0 0", name, busy, wr_req);
        end
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        checks++;
        if ({wr_req, busy, frame_ok, frame_err, err_code} !== 7'd0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b want 0000000", {wr_req, busy, frame_ok, frame_err, err_code});
        end
        checks++;
        if ({wr_sel, wr_addr, wr_data} !== 25'd0) begin
            failures++;
            $display("FAIL reset_bus: got %h want 0", {wr_sel, wr_addr, wr_data});
        end
        rst_n = 1'b1;
        tick(2);
    endtask
    task automatic test_noise();
        int ok0, err0;
        logic [7:0] b;
        ok0 = ok_cnt;
        err0 = err_cnt;
        wq.delete();
        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom);
            send_byte(b == 8'hA5 ? 8'h5A : b, $urandom_range(0, 2));
        end
        tick(3);
        checks++;
        if (busy !== 1'b0 || ok_cnt != ok0 || err_cnt != err0 || wq.size() != 0) begin
            failures++;
            $display("FAIL noise: busy=%b pulses=%0d writes=%0d want 0 0 0", busy,
                     ok_cnt - ok0 + err_cnt - err0, wq.size());
        end
    endtask
    task automatic test_ram_frame();
        run_frame("ram_c000", 8'h01, 16'hC000, 3, '{8'h11, 8'h22, 8'h33}, 1'b0, 2, 6);
    endtask
    task automatic test_vic_frame();
        run_frame("vic_20", 8'h02, 16'h0020, 2, '{8'h0E, 8'h06}, 1'b0, 2, 6);
    endtask
    task automatic test_vic_range();
        int ok0, err0;
        run_frame("vic_range", 8'h02, 16'h003F, 2, '{8'h0E, 8'h06}, 1'b0, 2, 6);
        ok0 = ok_cnt;
        err0 = err_cnt;
        send_byte(8'h0E, 2);
        send_byte(8'h06, 2);
        send_byte(8'h37, 2);
        tick(3);
        checks++;
        if (busy !== 1'b0 || ok_cnt != ok0 || err_cnt != err0 || wq.size() != 0) begin
            failures++;
            $display("FAIL vic_range_tail: busy=%b pulses=%0d writes=%0d want 0 0 0", busy,
                     ok_cnt - ok0 + err_cnt - err0, wq.size());
        end
        run_frame("vic_top_edge", 8'h02, 16'h003E, 2, '{8'h55, 8'hAA}, 1'b0, 2, 6);
    endtask
    task automatic test_ram_wrap();
        run_frame("ram_wrap", 8'h01, 16'hFFFF, 2, '{8'hAA, 8'hBB}, 1'b0, 2, 6);
    endtask
    task automatic test_checksum();
        run_frame("bad_chk", 8'h01, 16'h2000, 3, '{8'hA5, 8'h5A, 8'hA5}, 1'b1, 2, 6);
        run_frame("after_bad_chk", 8'h01, 16'h2100, 2, '{8'hA5, 8'h01}, 1'b0, 2, 6);
        checks++;
        if (err_code !== 3'd5) begin
            failures++;
            $display("FAIL err_code_held: got %0d want 5", err_code);
        end
    endtask
    task automatic test_bad_cmd();
        run_frame("bad_cmd", 8'h07, 16'h0000, 1, '{8'h00}, 1'b0, 2, 6);
    endtask
    task automatic test_timeout();
        int n;
        send_byte(8'hA5, 2);
        send_byte(8'h01, 2);
        send_byte(8'h12, 2);
        send_byte(8'h34, 0);
        n = 0;
        while (!frame_err && n < TMO + 20) begin
            tick(1);
            n++;
        end
        checks++;
        if (frame_err !== 1'b1 || err_code !== 3'd3) begin
            failures++;
            $display("FAIL timeout_code: frame_err=%b code=%0d want 1 3", frame_err, err_code);
        end
        checks++;
        if (n < TMO - 2 || n > TMO + 2) begin
            failures++;
            $display("FAIL timeout_delay: got %0d clks want %0d", n, TMO);
        end
        tick(2);
    endtask
    task automatic test_overrun();
        int n;
        wq.delete();
        ack_hold = 1'b1;
        send_byte(8'hA5, 2);
        send_byte(8'h01, 2);
        send_byte(8'h40, 2);
        send_byte(8'h00, 2);
        send_byte(8'h05, 2);
        send_byte(8'h71, 2);
        send_byte(8'h72, 2);
        send_byte(8'h73, 0);
        n = 0;
        while (!frame_err && n < 10) begin
            tick(1);
            n++;
        end
        checks++;
        if (frame_err !== 1'b1 || err_code !== 3'd4) begin
            failures++;
            $display("FAIL overrun_code: frame_err=%b code=%0d want 1 4", frame_err, err_code);
        end
        checks++;
        if (wr_req !== 1'b1) begin
            failures++;
            $display("FAIL overrun_inflight: wr_req=%b want 1", wr_req);
        end
        ack_hold = 1'b0;
        tick(10);
        checks++;
        if (wq.size() != 1 || wq[0] !== {1'b0, 16'h4000, 8'h71}) begin
            failures++;
            $display("FAIL overrun_writes: count=%0d first=%h want 1 %h", wq.size(),
                     wq.size() > 0 ? wq[0] : 25'd0, {1'b0, 16'h4000, 8'h71});
        end
        run_frame("after_overrun", 8'h01, 16'h4100, 4, rand_pl(4), 1'b0, 4, 8);
    endtask
    task automatic test_back_to_back();
        max_dly = 0;
        run_frame("b2b_32", 8'h01, 16'h8000, 32, rand_pl(32), 1'b0, 1, 1);
        run_frame("b2b_len256", 8'h01, 16'hFF80, 256, rand_pl(256), 1'b0, 1, 1);
        run_frame("b2b_vic", 8'h02, 16'h0000, 64, rand_pl(64), 1'b0, 1, 1);
        max_dly = 2;
    endtask
    task automatic test_random();
        logic [15:0] addr;
        int len;
        bit vic;
        for (int k = 0; k < 10; k++) begin
            vic = 1'($urandom);
            addr = vic ? 16'($urandom_range(0, 70)) : 16'($urandom);
            len = vic ? $urandom_range(1, 24) : $urandom_range(1, 40);
            max_dly = $urandom_range(0, 2);
            run_frame($sformatf("rand%0d", k), vic ? 8'h02 : 8'h01, addr, len, rand_pl(len),
                      $urandom_range(0, 4) == 0, 4, 8);
        end
        max_dly = 2;
    endtask
    task automatic test_reset_mid();
        wq.delete();
        ack_hold = 1'b1;
        send_byte(8'hA5, 2);
        send_byte(8'h01, 2);
        send_byte(8'h10, 2);
        send_byte(8'h00, 2);
        send_byte(8'h04, 2);
        send_byte(8'h99, 2);
        checks++;
        if (wr_req !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_before: wr_req=%b busy=%b want 1 1", wr_req, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (wr_req !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: wr_req=%b busy=%b want 0 0", wr_req, busy);
        end
        ack_hold = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        checks++;
        if (wq.size() != 0) begin
            failures++;
            $display("FAIL mid_writes: got %0d want 0", wq.size());
        end
        run_frame("after_reset", 8'h02, 16'h0010, 3, rand_pl(3), 1'b0, 4, 8);
    endtask
    task automatic test_invariants();
        checks++;
        if (both_cnt != 0) begin
            failures++;
            $display("FAIL ok_err_together: got %0d want 0", both_cnt);
        end
        checks++;
        if (busy_viol != 0) begin
            failures++;
            $display("FAIL busy_at_pulse: got %0d want 0", busy_viol);
        end
        checks++;
        if (stab_viol != 0) begin
            failures++;
            $display("FAIL bus_stable: got %0d changes want 0", stab_viol);
        end
    endtask
    initial begin
        rx_data = 8'h00;
        rx_valid = 1'b0;
        rst_n = 1'b0;
        test_reset();
        test_noise();
        test_ram_frame();
        test_vic_frame();
        test_vic_range();
        test_ram_wrap();
        test_checksum();
        test_bad_cmd();
        test_timeout();
        test_overrun();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_invariants();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
